// File: rtl/opm_pkg.sv
// Shared constants for the online power-model window controller:
// datapath geometry, default weights, pipeline flush depth and FSM encoding.
package opm_pkg;

    localparam int B       = 6;
    localparam int N       = 5;
    localparam int OUTSIZE = 10;
    localparam int WIN_W   = 16;
    localparam int FLUSH   = 3;
    localparam int IDX_W   = 3;
    localparam int SUM_W   = OUTSIZE + WIN_W;
    localparam int FL_W    = (FLUSH > 2) ? $clog2(FLUSH) : 1;

    localparam logic [B-1:0] W0 = 6'd23;
    localparam logic [B-1:0] W1 = 6'd25;
    localparam logic [B-1:0] W2 = 6'd24;
    localparam logic [B-1:0] W3 = 6'd11;
    localparam logic [B-1:0] W4 = 6'd45;

    localparam logic [N*B-1:0] W_RESET = {W4, W3, W2, W1, W0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/opm_weight_regs.sv
// Per-signal weight register file; writes land one cycle after cfg_we and only while idle.
// Rejected writes (busy or out-of-range index) raise a sticky cfg_err.
module opm_weight_regs
    import opm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             clr_err,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [B-1:0]     cfg_wdata,
    output logic [N*B-1:0]   weights,
    output logic             cfg_err
);

    logic [N*B-1:0] weights_q, weights_d;
    logic           cfg_err_q, cfg_err_d;
    logic           wr_ok;

    always_comb begin
        wr_ok     = cfg_we && idle && (cfg_idx < IDX_W'(N));
        weights_d = weights_q;
        cfg_err_d = cfg_err_q;
        if (wr_ok) begin
            weights_d[int'(cfg_idx)*B +: B] = cfg_wdata;
        end
        if (clr_err) begin
            cfg_err_d = 1'b0;
        end
        // A rejected write in the same cycle as a start still reports the error.
        if (cfg_we && !wr_ok) begin
            cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            weights_q <= W_RESET;
            cfg_err_q <= 1'b0;
        end else begin
            weights_q <= weights_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign weights = weights_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: rtl/opm_window_ctrl.sv
// Measurement-window sequencer: flushes the datapath pipeline, accumulates sum/peak/count
// over win_len samples, then holds the result until the consumer takes it (valid/ready).
module opm_window_ctrl
    import opm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [IDX_W-1:0]     cfg_idx,
    input  logic [B-1:0]         cfg_wdata,
    output logic                 cfg_err,
    output logic [N*B-1:0]       weights,
    input  logic                 start,
    input  logic [WIN_W-1:0]     win_len,
    output logic                 busy,
    input  logic [OUTSIZE-1:0]   pwr_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [SUM_W-1:0]     res_sum,
    output logic [OUTSIZE-1:0]   res_peak,
    output logic [WIN_W-1:0]     res_cycles
);

    state_e               state_q, state_d;
    logic [WIN_W-1:0]     len_q, len_d;
    logic [FL_W-1:0]      fl_cnt_q, fl_cnt_d;
    logic [WIN_W-1:0]     cnt_q, cnt_d;
    logic [SUM_W-1:0]     acc_q, acc_d;
    logic [OUTSIZE-1:0]   peak_q, peak_d;
    logic [SUM_W-1:0]     res_sum_q, res_sum_d;
    logic [OUTSIZE-1:0]   res_peak_q, res_peak_d;
    logic [WIN_W-1:0]     res_cycles_q, res_cycles_d;
    logic                 idle;
    logic                 start_ok;

    assign idle     = (state_q == ST_IDLE);
    assign start_ok = idle && start;

    opm_weight_regs u_weight_regs (
        .clk       (clk),
        .rst       (rst),
        .idle      (idle),
        .clr_err   (start_ok),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_wdata (cfg_wdata),
        .weights   (weights),
        .cfg_err   (cfg_err)
    );

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        fl_cnt_d     = fl_cnt_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        peak_d       = peak_q;
        res_sum_d    = res_sum_q;
        res_peak_d   = res_peak_q;
        res_cycles_d = res_cycles_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d    = win_len;
                    fl_cnt_d = '0;
                    cnt_d    = '0;
                    acc_d    = '0;
                    peak_d   = '0;
                    if (win_len == '0) begin
                        state_d      = ST_DONE;
                        res_sum_d    = '0;
                        res_peak_d   = '0;
                        res_cycles_d = '0;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (fl_cnt_q == FL_W'(FLUSH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    fl_cnt_d = fl_cnt_q + FL_W'(1);
                end
            end
            ST_RUN: begin
                acc_d  = acc_q + SUM_W'(pwr_in);
                peak_d = (pwr_in > peak_q) ? pwr_in : peak_q;
                cnt_d  = cnt_q + WIN_W'(1);
                // Results capture the current sample too, so DONE is entered on the last sample edge.
                if (cnt_d == len_q) begin
                    state_d      = ST_DONE;
                    res_sum_d    = acc_d;
                    res_peak_d   = peak_d;
                    res_cycles_d = cnt_d;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            fl_cnt_q     <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            peak_q       <= '0;
            res_sum_q    <= '0;
            res_peak_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            fl_cnt_q     <= fl_cnt_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            peak_q       <= peak_d;
            res_sum_q    <= res_sum_d;
            res_peak_q   <= res_peak_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    assign busy       = !idle;
    assign res_valid  = (state_q == ST_DONE);
    assign res_sum    = res_sum_q;
    assign res_peak   = res_peak_q;
    assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_opm_window_ctrl.sv
// Scoreboard bench for opm_window_ctrl: stimulus pushes expected window results,
// a negedge monitor pops and compares them on every valid&&ready handshake.
module tb_opm_window_ctrl;
    import opm_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_we;
    logic [IDX_W-1:0]     cfg_idx;
    logic [B-1:0]         cfg_wdata;
    logic                 cfg_err;
    logic [N*B-1:0]       weights;
    logic                 start;
    logic [WIN_W-1:0]     win_len;
    logic                 busy;
    logic [OUTSIZE-1:0]   pwr_in;
    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_W-1:0]     res_sum;
    logic [OUTSIZE-1:0]   res_peak;
    logic [WIN_W-1:0]     res_cycles;

    typedef struct {
        logic [SUM_W-1:0]   sum;
        logic [OUTSIZE-1:0] peak;
        logic [WIN_W-1:0]   cyc;
    } exp_t;

    exp_t               sb_q[$];
    logic [OUTSIZE-1:0] pwr_seq [0:15];
    logic [N*B-1:0]     exp_w;
    int                 checks = 0;
    int                 errors = 0;
    int                 dflt [5] = '{23, 25, 24, 11, 45};

    always #5 clk = ~clk;

    opm_window_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_wdata  (cfg_wdata),
        .cfg_err    (cfg_err),
        .weights    (weights),
        .start      (start),
        .win_len    (win_len),
        .busy       (busy),
        .pwr_in     (pwr_in),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_peak   (res_peak),
        .res_cycles (res_cycles)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue start, feed pwr_seq (index = edge-1 after the start edge), wait for the result,
    // hold it for 'hold' cycles with ready low, then hand it over.
    task automatic run_window(input int len, input logic [SUM_W-1:0] s, input logic [OUTSIZE-1:0] p,
                              input int mid_we, input int mid_start, input int hold);
        int   n;
        exp_t e;
        e.sum = s;
        e.peak = p;
        e.cyc = len[WIN_W-1:0];
        sb_q.push_back(e);
        win_len = len[WIN_W-1:0];
        start = 1'b1;
        pwr_in = 10'd1;
        tick;
        start = 1'b0;
        cfg_we = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            pwr_in = pwr_seq[(n < 16) ? n : 15];
            cfg_we = (n + 1 == mid_we);
            start  = (n + 1 == mid_start);
            tick;
            n++;
        end
        start = 1'b0;
        cfg_we = 1'b0;
        chk("res_valid_seen", res_valid, 1);
        chk("latency", n, (len == 0) ? 0 : FLUSH + len);
        repeat (hold) begin
            pwr_in = 10'($urandom);
            tick;
            chk("hold_valid", res_valid, 1);
            chk("hold_sum", res_sum, s);
            chk("hold_cycles", res_cycles, len);
        end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        chk("valid_drop", res_valid, 0);
        chk("idle_after", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_sum", res_sum, e.sum);
                chk("res_peak", res_peak, e.peak);
                chk("res_cycles", res_cycles, e.cyc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_wdata = '0;
        start = 1'b0; win_len = '0; pwr_in = '0; res_ready = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) chk("weight_rst", weights[i*B +: B], dflt[i]);
        chk("busy_rst", busy, 0);
        chk("valid_rst", res_valid, 0);
        chk("err_rst", cfg_err, 0);
        chk("sum_rst", res_sum, 0);
        exp_w = {6'd45, 6'd11, 6'd24, 6'd25, 6'd23};

        // Constant 128 over 4 samples, held 5 cycles before acceptance.
        for (int i = 0; i < 16; i++) pwr_seq[i] = 10'd128;
        run_window(4, 512, 128, -1, -1, 5);
        chk("res_kept_in_idle", res_sum, 512);

        // Flush samples are large and must be ignored.
        for (int i = 0; i < 16; i++) pwr_seq[i] = 10'd0;
        pwr_in = 10'd7; tick; pwr_in = 10'd9; tick;
        pwr_seq[0] = 10'd1000; pwr_seq[1] = 10'd1000; pwr_seq[2] = 10'd1000;
        pwr_seq[3] = 10'd5; pwr_seq[4] = 10'd70; pwr_seq[5] = 10'd3;
        run_window(3, 78, 70, -1, -1, 1);

        // Weight writes: legal, out-of-range.
        cfg_idx = 3'd2; cfg_wdata = 6'd63; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        exp_w[12 +: 6] = 6'd63;
        chk("w2_write", weights[17:12], 63);
        chk("err_after_ok", cfg_err, 0);
        cfg_idx = 3'd5; cfg_wdata = 6'd9; cfg_we = 1'b1;
        tick;
        cfg_we = 1'b0;
        chk("err_bad_idx", cfg_err, 1);
        chk("w_after_bad_idx", weights, exp_w);

        // Write and restart attempt during RUN are both ignored.
        cfg_idx = 3'd0; cfg_wdata = 6'd1;
        for (int i = 0; i < 16; i++) pwr_seq[i] = 10'd0;
        pwr_seq[0] = 10'd1000; pwr_seq[1] = 10'd1000; pwr_seq[2] = 10'd1000;
        pwr_seq[3] = 10'd10; pwr_seq[4] = 10'd20; pwr_seq[5] = 10'd30;
        pwr_seq[6] = 10'd40; pwr_seq[7] = 10'd50;
        run_window(5, 150, 50, 5, 6, 0);
        chk("err_busy_write", cfg_err, 1);
        chk("w_after_busy_write", weights, exp_w);

        // Zero-length window with a simultaneous legal write; start clears cfg_err.
        cfg_idx = 3'd1; cfg_wdata = 6'd33; cfg_we = 1'b1;
        run_window(0, 0, 0, -1, -1, 2);
        exp_w[6 +: 6] = 6'd33;
        chk("w_write_with_start", weights, exp_w);
        chk("err_cleared_by_start", cfg_err, 0);

        // Reset in the middle of RUN.
        for (int i = 0; i < 16; i++) pwr_seq[i] = 10'd500;
        pwr_in = 10'd500; win_len = 16'd4; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("busy_mid_rst", busy, 0);
        chk("valid_mid_rst", res_valid, 0);
        chk("w_mid_rst", weights, {6'd45, 6'd11, 6'd24, 6'd25, 6'd23});
        chk("sum_mid_rst", res_sum, 0);
        exp_w = {6'd45, 6'd11, 6'd24, 6'd25, 6'd23};
        for (int i = 0; i < 16; i++) pwr_seq[i] = 10'd0;
        pwr_seq[0] = 10'd1000; pwr_seq[1] = 10'd1000; pwr_seq[2] = 10'd1000;
        pwr_seq[3] = 10'd300; pwr_seq[4] = 10'd700;
        run_window(2, 1000, 700, -1, -1, 0);
        chk("w_after_rst_window", weights, exp_w);

        tick;
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opm_window_ctrl.md
Name: opm_window_ctrl

Overview:
- Sequencer and configurator for the online power-model datapath (per-cycle weighted-toggle power sum, registered output, 3-cycle pipeline latency from input signals to power value).
- Owns the per-signal weight registers that drive the datapath, runs measurement windows, and returns window totals to a consumer over a valid/ready handshake.
- Sits between a host or config master and one datapath instance; it consumes the datapath's registered per-cycle power output.

Parameters:
- B, 6: weight width in bits.
- n, 5: number of monitored signals (weights).
- outsize, 10: width of the per-cycle power input; requires n*(2^B-1) <= 2^outsize-1.
- win_w, 16: width of the window length and cycle count.
- flush, 3: number of datapath samples discarded after start (pipeline fill).
- idx_w, 3: width of the weight index; requires 2^idx_w >= n.

Ports:
- clk  in  1  single clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  weight write strobe.
- cfg_idx  in  idx_w  weight index to write.
- cfg_wdata  in  B  new weight value.
- cfg_err  out  1  sticky flag: a write was rejected.
- weights  out  n*B  flat weight bus to the datapath; weight i occupies bits [i*B +: B].
- start  in  1  request to begin a measurement window.
- win_len  in  win_w  number of samples to accumulate; latched when start is accepted.
- busy  out  1  high in every state except IDLE.
- pwr_in  in  outsize  registered per-cycle power value from the datapath.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_sum  out  outsize+win_w  sum of accumulated samples.
- res_peak  out  outsize  maximum accumulated sample.
- res_cycles  out  win_w  number of samples accumulated.

Behaviour:
- Reset values:
  - state = IDLE.
  - weights = {45,11,24,25,23} for i=4..0 (binary 101101, 001011, 011000, 011001, 010111).
  - cfg_err, busy and res_valid = 0.
  - res_sum, res_peak, res_cycles and all internal counters = 0.
- Reset asserted in any state aborts the window immediately. There is no partial result.
- Weight writes:
  - Accepted only in IDLE with cfg_idx < n.
  - The new value appears on weights the cycle after the cfg_we edge.
  - A write while busy, or with cfg_idx >= n, is dropped and sets cfg_err.
  - cfg_err clears on rst or on an accepted start.
  - If cfg_we and start are both asserted in IDLE, the write is applied first, so the window uses the new weight.
- FSM states and transitions:
  - IDLE -> FLUSH on start; win_len is latched. If win_len==0, IDLE -> DONE instead, with sum, peak and cycles all 0.
  - FLUSH: ignores pwr_in for exactly flush cycles, then -> RUN.
  - RUN: on each cycle, adds pwr_in to acc, updates peak = max(peak, pwr_in) and increments cnt. After the win_len-th sample -> DONE.
  - DONE: res_valid=1 and the results are held stable while res_ready=0. On the valid&&ready edge -> IDLE and res_valid drops the next cycle.
- Latency: with start sampled at edge 0, the samples at edges flush+1 .. flush+win_len are accumulated, and res_valid is high from cycle flush+win_len+1.
- acc is outsize+win_w bits wide and cannot overflow; no saturation logic is needed. pwr_in is zero-extended.
- A start while busy is ignored, including the cycle of a DONE handshake.
- res_* registers are loaded on entry to DONE and keep their values in IDLE until the next DONE.
- Weights are constant throughout FLUSH, RUN and DONE.

Decomposition:
- Shared package opm_pkg holds:
  - default weight constants W0..W4;
  - state encoding (IDLE, FLUSH, RUN, DONE);
  - the FLUSH default, matching the datapath latency.
- One sub-module is natural: opm_weight_regs, which holds the weight register file, write-accept logic and cfg_err. The FSM and accumulator stay in the top level.

Test Plan:
- Reset then read weights -> 23,25,24,11,45 for idx 0..4; busy=0; res_valid=0.
- start with win_len=4, pwr_in=128 constant -> res_valid at cycle 8; sum=512, peak=128, cycles=4. Hold res_ready=0 for 5 cycles -> values stable; assert res_ready -> back to IDLE.
- win_len=3, pwr_in sequence 7,9,(flush samples 1000 ignored),5,70,3 -> sum=78, peak=70, cycles=3.
- Write idx 2 = 63 in IDLE -> weights[17:12]=63 next cycle. Write idx 5 -> ignored, cfg_err=1. Write during RUN -> ignored, cfg_err=1, weights unchanged.
- start with win_len=0 -> res_valid next cycle with all fields 0. A start pulse during RUN -> no effect on count.
- Assert rst mid-RUN -> busy=0, res_valid=0, weights return to defaults. The next start runs a full window correctly.
